// File: rtl/range_stats_unit.sv
// Range statistics unit: tracks min, max and sample count over a go..finish run
// and publishes min, max, range and count when the run completes.
module range_stats_unit #(
   parameter int WIDTH     = 8,
   parameter int CNT_WIDTH = 8,
   parameter int SIGNED    = 0
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic [WIDTH-1:0]     data_in,
   input  logic                 data_valid,
   input  logic                 go,
   input  logic                 finish,
   output logic [WIDTH-1:0]     range,
   output logic [WIDTH-1:0]     min_out,
   output logic [WIDTH-1:0]     max_out,
   output logic [CNT_WIDTH-1:0] count,
   output logic                 done,
   output logic                 busy,
   output logic                 error
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACTIVE = 2'd1,
      DONE   = 2'd2,
      ERROR  = 2'd3
   } state_t;

   state_t               state_q, state_d;
   logic [WIDTH-1:0]     run_min_q, run_min_d;
   logic [WIDTH-1:0]     run_max_q, run_max_d;
   logic [CNT_WIDTH-1:0] run_cnt_q, run_cnt_d;
   logic [WIDTH-1:0]     res_min_q, res_min_d;
   logic [WIDTH-1:0]     res_max_q, res_max_d;
   logic [WIDTH-1:0]     res_range_q, res_range_d;
   logic [CNT_WIDTH-1:0] res_cnt_q, res_cnt_d;
   logic                 done_q, done_d;
   logic                 busy_q, busy_d;
   logic                 error_q, error_d;

   logic [WIDTH-1:0]     fold_min;
   logic [WIDTH-1:0]     fold_max;
   logic [CNT_WIDTH-1:0] fold_cnt;
   logic                 cnt_full;

   function automatic logic is_less(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      if (SIGNED != 0) begin
         return $signed(a) < $signed(b);
      end
      return a < b;
   endfunction

   // Running state with the current sample folded in, used both for the
   // per-sample update and for the final result capture on finish.
   always_comb begin
      fold_min = run_min_q;
      fold_max = run_max_q;
      fold_cnt = run_cnt_q;
      cnt_full = &run_cnt_q;
      if (data_valid) begin
         fold_min = is_less(data_in, run_min_q) ? data_in : run_min_q;
         fold_max = is_less(run_max_q, data_in) ? data_in : run_max_q;
         fold_cnt = run_cnt_q + CNT_WIDTH'(1);
      end
   end

   always_comb begin
      state_d     = state_q;
      run_min_d   = run_min_q;
      run_max_d   = run_max_q;
      run_cnt_d   = run_cnt_q;
      res_min_d   = res_min_q;
      res_max_d   = res_max_q;
      res_range_d = res_range_q;
      res_cnt_d   = res_cnt_q;

      unique case (state_q)
         IDLE: begin
            if (finish) begin
               state_d = ERROR;
            end else if (go) begin
               state_d   = ACTIVE;
               run_min_d = data_in;
               run_max_d = data_in;
               run_cnt_d = CNT_WIDTH'(1);
            end
         end
         ACTIVE: begin
            // A sample that would wrap the counter aborts the run, even on finish.
            if (go || (data_valid && cnt_full)) begin
               state_d = ERROR;
            end else begin
               run_min_d = fold_min;
               run_max_d = fold_max;
               run_cnt_d = fold_cnt;
               if (finish) begin
                  state_d     = DONE;
                  res_min_d   = fold_min;
                  res_max_d   = fold_max;
                  res_range_d = fold_max - fold_min;
                  res_cnt_d   = fold_cnt;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         ERROR: begin
            if (go && !finish) begin
               state_d   = ACTIVE;
               run_min_d = data_in;
               run_max_d = data_in;
               run_cnt_d = CNT_WIDTH'(1);
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      done_d  = (state_d == DONE);
      busy_d  = (state_d == ACTIVE);
      error_d = (state_d == ERROR);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         run_min_q   <= '0;
         run_max_q   <= '0;
         run_cnt_q   <= '0;
         res_min_q   <= '0;
         res_max_q   <= '0;
         res_range_q <= '0;
         res_cnt_q   <= '0;
         done_q      <= 1'b0;
         busy_q      <= 1'b0;
         error_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         run_min_q   <= run_min_d;
         run_max_q   <= run_max_d;
         run_cnt_q   <= run_cnt_d;
         res_min_q   <= res_min_d;
         res_max_q   <= res_max_d;
         res_range_q <= res_range_d;
         res_cnt_q   <= res_cnt_d;
         done_q      <= done_d;
         busy_q      <= busy_d;
         error_q     <= error_d;
      end
   end

   assign range   = res_range_q;
   assign min_out = res_min_q;
   assign max_out = res_max_q;
   assign count   = res_cnt_q;
   assign done    = done_q;
   assign busy    = busy_q;
   assign error   = error_q;

endmodule

// File: doc/range_stats_unit.md
RANGE_STATS_UNIT -- requirements
Module: range_stats_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning the sample width in bits.
REQ-002 The block SHALL have parameter CNT_WIDTH, default 8, meaning the sample counter width in bits.
REQ-003 The block SHALL have parameter SIGNED, default 0, meaning samples compare as two's complement when 1 and unsigned when 0.
REQ-004 clock  input  1  sole clock, rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 data_in  input  WIDTH  sample bus.
REQ-007 data_valid  input  1  data_in holds a sample this cycle (ACTIVE only).
REQ-008 go  input  1  start a run; data_in is the first sample.
REQ-009 finish  input  1  end the run; the sample this cycle is included if data_valid=1.
REQ-010 range  output  WIDTH  max_out minus min_out of the last completed run.
REQ-011 min_out  output  WIDTH  minimum of the last completed run.
REQ-012 max_out  output  WIDTH  maximum of the last completed run.
REQ-013 count  output  CNT_WIDTH  number of samples in the last completed run.
REQ-014 done  output  1  one-cycle pulse when results update.
REQ-015 busy  output  1  high while state is ACTIVE.
REQ-016 error  output  1  high while state is ERROR.

Function
REQ-017 The FSM SHALL have exactly 4 states: IDLE, ACTIVE, DONE, ERROR.
REQ-018 IDLE: go=1, finish=0 -> ACTIVE; running min and max load data_in; running count loads 1.
REQ-019 IDLE: finish=1, with any go -> ERROR; otherwise stay in IDLE.
REQ-020 ACTIVE: go=1, with any finish -> ERROR; running state unchanged; results unchanged.
REQ-021 ACTIVE: data_valid=1 -> running min = lesser(min, data_in), running max = greater(max, data_in), count +1; all three update in the same edge.
REQ-022 ACTIVE: data_valid=0 -> running min, max and count hold.
REQ-023 ACTIVE: finish=1, go=0 -> DONE; on that edge results load from the running state including the current sample (combinational fold), range = final max - final min.
REQ-024 Results SHALL update only on the ACTIVE->DONE edge and hold until the next such edge or reset.
REQ-025 DONE SHALL last exactly 1 cycle with done=1, then go to IDLE unconditionally; go during DONE is ignored.
REQ-026 Count overflow: ACTIVE with data_valid=1 and count at all-ones -> ERROR, including when finish=1; results unchanged.
REQ-027 ERROR: go=1, finish=0 -> ACTIVE with a fresh capture as in REQ-018; otherwise stay in ERROR.
REQ-028 Comparisons SHALL follow SIGNED; range is WIDTH-bit unsigned and exact, since max >= min.
REQ-029 Latency SHALL be as follows: done and updated results are visible the cycle after finish is sampled.
REQ-030 data_valid SHALL be ignored outside ACTIVE.

Reset
REQ-031 Asserting reset SHALL immediately force IDLE; range, min_out, max_out, count, done, busy and error go to 0 and running registers clear.
REQ-032 Reset mid-run SHALL discard the run; results stay 0 until a later run completes.
REQ-033 After reset release, the first rising edge SHALL be evaluated as IDLE.

Verification
REQ-034 The bench SHALL cover: unsigned run go with 20; valid samples 5, 200; finish with valid sample 90 -> min_out=5, max_out=200, range=195, count=4, done pulse 1 cycle.
REQ-035 The bench SHALL cover: SIGNED=1 run of -100, 27, finish with valid sample -3 -> min_out=0x9C, max_out=0x1B, range=127, count=3.
REQ-036 The bench SHALL cover: go during ACTIVE -> error=1 next cycle and prior results unchanged; then go=1, finish=0 with 7 followed by finish with valid 7 -> range=0, count=2, error low.
REQ-037 The bench SHALL cover: finish in IDLE, and go+finish together in IDLE -> ERROR; busy=0; done never pulses.
REQ-038 The bench SHALL cover: CNT_WIDTH=2, go then 3 valid samples -> ERROR on the 4th sample edge; results unchanged.
REQ-039 The bench SHALL cover: reset asserted between clock edges mid-run -> outputs 0 without waiting for an edge; next run completes normally.
